// File: rtl/inv_pipe.sv
// inv_pipe: masked XOR inverter carried through STAGES valid/ready register stages with occupancy count.
// Define INV_PIPE_PARITY_EN to add out_parity, the even parity of out_data carried as an extra stage bit.
module inv_pipe #(
  parameter int WIDTH = 8,
  parameter int STAGES = 3,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef INV_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [OCC_W-1:0] occupancy
);
  logic [STAGES-1:0] v_q, v_d, rdy;
  logic [STAGES-1:0][WIDTH-1:0] d_q, d_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] x;
  logic r;
  assign x = in_data ^ in_mask;
  always_comb begin
    rdy = '0;
    r = out_ready;
    // a stage can take a word if it is empty or everything ahead of it moves
    for (int i = STAGES - 1; i >= 0; i--) begin
      r = ~v_q[i] | r;
      rdy[i] = r;
    end
  end
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    v_d[0] = rdy[0] ? in_valid : v_q[0];
    d_d[0] = (rdy[0] && in_valid) ? x : d_q[0];
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = rdy[i] ? v_q[i-1] : v_q[i];
      d_d[i] = (rdy[i] && v_q[i-1]) ? d_q[i-1] : d_q[i];
    end
    occ_d = occ_q + OCC_W'(in_valid & rdy[0]) - OCC_W'(v_q[STAGES-1] & out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
      occ_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      occ_q <= occ_d;
    end
  end
`ifdef INV_PIPE_PARITY_EN
  logic [STAGES-1:0] p_q, p_d;
  always_comb begin
    p_d = p_q;
    p_d[0] = (rdy[0] && in_valid) ? ^x : p_q[0];
    for (int i = 1; i < STAGES; i++) p_d[i] = (rdy[i] && v_q[i-1]) ? p_q[i-1] : p_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else p_q <= p_d;
  end
  assign out_parity = p_q[STAGES-1];
`endif
  assign in_ready = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data = d_q[STAGES-1];
  assign occupancy = occ_q;
endmodule
